// File: rtl/if_id_buffer.sv
// Two-entry IF->ID decoupling buffer (main + skid) with flush and
// saturating stall/flush counters; IF_READY comes only from flops.
module if_id_buffer #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] NOP_INS = '0,
  parameter int               CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IF_VALID,
  input  logic [WIDTH-1:0] IF_INS,
  input  logic [WIDTH-1:0] IF_NEXT_ADR,
  output logic             IF_READY,
  output logic             ID_VALID,
  output logic [WIDTH-1:0] ID_INS,
  output logic [WIDTH-1:0] ID_NEXT_ADR,
  input  logic             ID_READY,
  input  logic             FLUSH,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  logic             m_vld_q, m_vld_d;
  logic             s_vld_q, s_vld_d;
  logic [WIDTH-1:0] m_ins_q, m_ins_d;
  logic [WIDTH-1:0] m_adr_q, m_adr_d;
  logic [WIDTH-1:0] s_ins_q, s_ins_d;
  logic [WIDTH-1:0] s_adr_q, s_adr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic push;
  logic pop;

  assign push = IF_VALID & ~s_vld_q;
  assign pop  = m_vld_q & ID_READY;

  always_comb begin
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    m_ins_d = m_ins_q;
    m_adr_d = m_adr_q;
    s_ins_d = s_ins_q;
    s_adr_d = s_adr_q;
    if (FLUSH) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q) begin
      if (push) begin
        m_vld_d = 1'b1;
        m_ins_d = IF_INS;
        m_adr_d = IF_NEXT_ADR;
      end
    end else if (!s_vld_q) begin
      if (push && !pop) begin
        s_vld_d = 1'b1;
        s_ins_d = IF_INS;
        s_adr_d = IF_NEXT_ADR;
      end else if (push && pop) begin
        m_ins_d = IF_INS;
        m_adr_d = IF_NEXT_ADR;
      end else if (pop) begin
        m_vld_d = 1'b0;
      end
    end else if (pop) begin
      // skid entry moves up so the oldest always sits in M
      m_ins_d = s_ins_q;
      m_adr_d = s_adr_q;
      s_vld_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (m_vld_q && !ID_READY && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (FLUSH && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      m_vld_q     <= 1'b0;
      s_vld_q     <= 1'b0;
      m_ins_q     <= '0;
      m_adr_q     <= '0;
      s_ins_q     <= '0;
      s_adr_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      m_vld_q     <= m_vld_d;
      s_vld_q     <= s_vld_d;
      m_ins_q     <= m_ins_d;
      m_adr_q     <= m_adr_d;
      s_ins_q     <= s_ins_d;
      s_adr_q     <= s_adr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign IF_READY    = ~s_vld_q;
  assign ID_VALID    = m_vld_q;
  assign ID_INS      = m_vld_q ? m_ins_q : NOP_INS;
  assign ID_NEXT_ADR = m_vld_q ? m_adr_q : '0;
  assign STALL_CNT   = stall_cnt_q;
  assign FLUSH_CNT   = flush_cnt_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: vector table plus a queue scoreboard
// checked every cycle, with directed flush/reset/saturation runs.
module tb_if_id_buffer;

  localparam int W  = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IF_VALID;
  logic [W-1:0]  IF_INS;
  logic [W-1:0]  IF_NEXT_ADR;
  logic          IF_READY;
  logic          ID_VALID;
  logic [W-1:0]  ID_INS;
  logic [W-1:0]  ID_NEXT_ADR;
  logic          ID_READY;
  logic          FLUSH;
  logic [CW-1:0] STALL_CNT;
  logic [CW-1:0] FLUSH_CNT;

  if_id_buffer #(
    .WIDTH  (W),
    .NOP_INS(32'h00000000),
    .CNT_W  (CW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IF_VALID   (IF_VALID),
    .IF_INS     (IF_INS),
    .IF_NEXT_ADR(IF_NEXT_ADR),
    .IF_READY   (IF_READY),
    .ID_VALID   (ID_VALID),
    .ID_INS     (ID_INS),
    .ID_NEXT_ADR(ID_NEXT_ADR),
    .ID_READY   (ID_READY),
    .FLUSH      (FLUSH),
    .STALL_CNT  (STALL_CNT),
    .FLUSH_CNT  (FLUSH_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic [31:0] adr;
    logic        idr;
    logic        fl;
    logic        rst;
    logic        e_vld;
    logic [31:0] e_ins;
    logic [31:0] e_adr;
    logic        e_rdy;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock: drive, let the scoreboard react to the edge, then compare.
  task automatic cyc(input logic iv, input logic [31:0] ins,
                     input logic [31:0] adr, input logic idr,
                     input logic fl, input logic rst);
    bit m_rdy;
    bit m_vld;
    IF_VALID    = iv;
    IF_INS      = ins;
    IF_NEXT_ADR = adr;
    ID_READY    = idr;
    FLUSH       = fl;
    RST         = rst;
    @(posedge CLK);
    m_rdy = sb.size() < 2;
    m_vld = sb.size() > 0;
    if (rst) begin
      sb.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (m_vld && !idr && m_stall < CMAX) m_stall++;
      if (fl) begin
        if (m_flush < CMAX) m_flush++;
        sb.delete();
      end else begin
        if (m_vld && idr) void'(sb.pop_front());
        if (iv && m_rdy) sb.push_back({ins, adr});
      end
    end
    #1;
    chk("sb_id_valid", {31'd0, ID_VALID}, {31'd0, sb.size() > 0});
    chk("sb_id_ins", ID_INS, sb.size() > 0 ? sb[0][63:32] : 32'h0);
    chk("sb_id_adr", ID_NEXT_ADR, sb.size() > 0 ? sb[0][31:0] : 32'h0);
    chk("sb_if_ready", {31'd0, IF_READY}, {31'd0, sb.size() < 2});
    chk("sb_stall_cnt", {28'd0, STALL_CNT}, m_stall);
    chk("sb_flush_cnt", {28'd0, FLUSH_CNT}, m_flush);
  endtask

  function automatic vec_t mk(logic iv, logic [31:0] ins,
                              logic [31:0] adr, logic idr, logic fl,
                              logic rst, logic ev, logic [31:0] ei,
                              logic [31:0] ea, logic er);
    vec_t v;
    v.iv = iv; v.ins = ins; v.adr = adr;
    v.idr = idr; v.fl = fl; v.rst = rst;
    v.e_vld = ev; v.e_ins = ei; v.e_adr = ea; v.e_rdy = er;
    return v;
  endfunction

  vec_t tv[8];

  initial begin
    RST = 1'b1; IF_VALID = 1'b0; IF_INS = '0;
    IF_NEXT_ADR = '0; ID_READY = 1'b0; FLUSH = 1'b0;

    tv[0] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    tv[1] = mk(1, 32'h8C220004, 4, 1, 0, 0, 1, 32'h8C220004, 4, 1);
    tv[2] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    tv[3] = mk(1, 32'hAAAA0001, 4, 0, 0, 0, 1, 32'hAAAA0001, 4, 1);
    tv[4] = mk(1, 32'hBBBB0002, 8, 0, 0, 0, 1, 32'hAAAA0001, 4, 0);
    tv[5] = mk(1, 32'hCCCC0003, 12, 1, 0, 0, 1, 32'hBBBB0002, 8, 1);
    tv[6] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    tv[7] = mk(1, 32'hDDDD0004, 16, 0, 1, 0, 0, 0, 0, 1);

    for (int i = 0; i < 8; i++) begin
      cyc(tv[i].iv, tv[i].ins, tv[i].adr, tv[i].idr,
          tv[i].fl, tv[i].rst);
      chk($sformatf("tv%0d_vld", i), {31'd0, ID_VALID},
          {31'd0, tv[i].e_vld});
      chk($sformatf("tv%0d_ins", i), ID_INS, tv[i].e_ins);
      chk($sformatf("tv%0d_adr", i), ID_NEXT_ADR, tv[i].e_adr);
      chk($sformatf("tv%0d_rdy", i), {31'd0, IF_READY},
          {31'd0, tv[i].e_rdy});
    end
    chk("tv_flush_cnt", {28'd0, FLUSH_CNT}, 32'd1);

    // streaming: one in, one out per cycle, never full
    for (int i = 0; i < 10; i++) begin
      cyc(1, 32'h1000_0000 + i, 4 * (i + 1), 1, 0, 0);
      chk("stream_ins", ID_INS, 32'h1000_0000 + i);
      chk("stream_rdy", {31'd0, IF_READY}, 32'd1);
    end
    cyc(0, 0, 0, 1, 0, 0);
    chk("stream_drain", {31'd0, ID_VALID}, 32'd0);

    // fill, then flush with a push and a pop in the same cycle
    cyc(1, 32'hE0000001, 4, 0, 0, 0);
    cyc(1, 32'hE0000002, 8, 0, 0, 0);
    chk("full_rdy", {31'd0, IF_READY}, 32'd0);
    cyc(1, 32'hE0000003, 12, 1, 1, 0);
    chk("flush_vld", {31'd0, ID_VALID}, 32'd0);
    chk("flush_ins", ID_INS, 32'h0);
    chk("flush_rdy", {31'd0, IF_READY}, 32'd1);
    chk("flush_cnt2", {28'd0, FLUSH_CNT}, 32'd2);
    cyc(0, 0, 0, 1, 0, 0);
    chk("flush_gone", {31'd0, ID_VALID}, 32'd0);

    // stall counter saturation
    cyc(1, 32'hF0000001, 4, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("stall_sat", {28'd0, STALL_CNT}, CMAX);
    chk("stall_hold_ins", ID_INS, 32'hF0000001);

    // flush counter saturation
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("flush_sat", {28'd0, FLUSH_CNT}, CMAX);

    // random traffic
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, $urandom,
          1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, 0);

    // reset over a full buffer with flush asserted
    cyc(1, 32'h77770001, 4, 0, 0, 0);
    cyc(1, 32'h77770002, 8, 0, 0, 0);
    cyc(1, 32'h77770003, 12, 0, 0, 0);
    chk("pre_rst_full", {31'd0, IF_READY}, 32'd0);
    cyc(1, 32'h77770004, 16, 0, 1, 1);
    chk("rst_vld", {31'd0, ID_VALID}, 32'd0);
    chk("rst_stall", {28'd0, STALL_CNT}, 32'd0);
    chk("rst_flush", {28'd0, FLUSH_CNT}, 32'd0);
    chk("rst_rdy", {31'd0, IF_READY}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
